// File: rtl/booth_pp_csa_accumulator.sv
// ---------------------------------------------------------------------------
// booth_pp_csa_accumulator
//
// Sequential carry-save reducer for Booth radix-4 partial products. Each
// accepted beat folds one pair of W-bit partial products into a registered
// carry-save accumulator (acc_s/acc_c) through a row of W 4:2 compressors.
// After NBEATS beats the carry-save pair is offered on a valid/ready output.
// All arithmetic is modulo 2^W.
//
// Optional feature (macro BOOTH_CSA_CPA_EN): an extra ADD state resolves the
// carry-save pair with a carry-propagate add before presenting it, so the
// output is out_sum = acc_s + acc_c and out_carry = 0 (latency 2 from the
// last beat instead of 1).
//
// Ports:
//   sys_clk    in   rising-edge clock
//   sys_rst_n  in   asynchronous active-low reset
//   clear      in   synchronous abort of the current accumulation
//   in_valid   in   partial-product pair valid
//   in_ready   out  block can accept a pair (state ACC)
//   in_pp0     in   partial product A, sign-extended and weight-aligned
//   in_pp1     in   partial product B, aligned the same way
//   out_valid  out  result valid (state OUT)
//   out_ready  in   downstream accepts result
//   out_sum    out  carry-save sum vector (or resolved sum with CPA)
//   out_carry  out  carry-save carry vector, already at its weight
//   busy       out  at least one beat accepted for the current result
// ---------------------------------------------------------------------------
module booth_pp_csa_accumulator #(
  parameter int W      = 32,
  parameter int NBEATS = 8
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pp0,
  input  logic [W-1:0] in_pp1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic [W-1:0] out_carry,
  output logic         busy
);

  localparam int CNT_W = $clog2(NBEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    ST_ACC = 2'd0,
`ifdef BOOTH_CSA_CPA_EN
    ST_ADD = 2'd1,
`endif
    ST_OUT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     acc_s;
  logic [W-1:0]     acc_c;

  // Compressor operands. On the first beat of a result the accumulator is
  // masked off, so a finished or aborted result never needs a zeroing cycle.
  logic [W-1:0] s_in;
  logic [W-1:0] c_in;
  logic [W-1:0] x_pre;     // pp0 ^ pp1, precomputed per column
  logic [W-1:0] n_pre;     // ~(pp0 & pp1), precomputed per column
  logic [W-1:0] row_d;     // new sum vector
  logic [W-1:0] row_c;     // new carry vector, bit k still at weight k

  assign s_in  = (cnt == '0) ? '0 : acc_s;
  assign c_in  = (cnt == '0) ? '0 : acc_c;
  assign x_pre = in_pp0 ^ in_pp1;
  assign n_pre = ~(in_pp0 & in_pp1);

  // Row of 4:2 compressors. The column-to-column carry (co) rippled here only
  // depends on this column's pp0/pp1/s_in, so the chain is one gate deep per
  // column and does not propagate through t/d/c.
  always_comb begin
    logic ci;
    logic t;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and a latch is never inferred.
    row_d = '0;
    row_c = '0;
    ci    = 1'b0;
    t     = 1'b0;
    for (int k = 0; k < W; k++) begin
      t        = x_pre[k] ^ s_in[k];
      row_d[k] = t ^ c_in[k] ^ ci;
      row_c[k] = (t & c_in[k]) | (t & ci) | (c_in[k] & ci);
      ci       = ~(~(x_pre[k] & s_in[k]) & n_pre[k]);
    end
  end

`ifdef BOOTH_CSA_CPA_EN
  logic [W-1:0] out_sum_q;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_ACC;
      cnt   <= '0;
      acc_s <= '0;
      acc_c <= '0;
`ifdef BOOTH_CSA_CPA_EN
      out_sum_q <= '0;
`endif
    end else if (clear) begin
      // Abort wins over both a presented beat and the output handshake.
      state <= ST_ACC;
      cnt   <= '0;
    end else begin
      case (state)
        ST_ACC: begin
          if (in_valid) begin
            acc_s <= row_d;
            // Carry of column k has weight k+1; the top carry falls off.
            acc_c <= row_c << 1;
            cnt   <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
`ifdef BOOTH_CSA_CPA_EN
              state <= ST_ADD;
`else
              state <= ST_OUT;
`endif
            end
          end
        end
`ifdef BOOTH_CSA_CPA_EN
        ST_ADD: begin
          out_sum_q <= acc_s + acc_c;
          state     <= ST_OUT;
        end
`endif
        ST_OUT: begin
          if (out_ready) begin
            state <= ST_ACC;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_ACC;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state == ST_ACC);
  assign out_valid = (state == ST_OUT);
  assign busy      = (cnt != '0) || (state != ST_ACC);

`ifdef BOOTH_CSA_CPA_EN
  assign out_sum   = out_sum_q;
  assign out_carry = '0;
`else
  // The accumulator is frozen outside ACC, so the raw pair is stable in OUT.
  assign out_sum   = acc_s;
  assign out_carry = acc_c;
`endif

endmodule

// File: tb/tb_booth_pp_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_booth_pp_csa_accumulator
//
// Self-checking bench for booth_pp_csa_accumulator at W=16, NBEATS=4.
// Expected results come from a plain modular sum of the pairs fed in; the
// carry-save pair is only ever judged through (out_sum + out_carry).
// ---------------------------------------------------------------------------
module tb_booth_pp_csa_accumulator;

  localparam int W      = 16;
  localparam int NBEATS = 4;
`ifdef BOOTH_CSA_CPA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         sys_clk;
  logic         sys_rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_pp0;
  logic [W-1:0] in_pp1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [W-1:0] out_carry;
  logic         busy;

  int checks;
  int errors;

  booth_pp_csa_accumulator #(.W(W), .NBEATS(NBEATS)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pp0    (in_pp0),
    .in_pp1    (in_pp1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Reference model: the result is simply the modular sum of every pair.
  function automatic logic [W-1:0] pair_sum(input logic [W-1:0] a[NBEATS],
                                            input logic [W-1:0] b[NBEATS]);
    int unsigned total;
    total = 0;
    for (int i = 0; i < NBEATS; i++) total += int'(a[i]) + int'(b[i]);
    return W'(total);
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    in_pp0   = a;
    in_pp1   = b;
    tick();
    in_valid = 1'b0;
    in_pp0   = '0;
    in_pp1   = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called right after the last beat's edge; returns cycles until out_valid
  // (1 means valid already after that edge), or 0 if it never arrived.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = 0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    idle(2);
    sys_rst_n = 1'b1;
    tick();
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: got rdy/val/busy=%b required 100", {in_ready, out_valid, busy});
    end
    checks++;
    if (out_sum !== '0 || out_carry !== '0) begin
      errors++;
      $display("FAIL reset_data: got sum=%h carry=%h required 0/0", out_sum, out_carry);
    end
  endtask

  // Shared by basic-sum and wrap-around: fixed pairs, back-to-back.
  task automatic run_fixed(input string name, input logic [W-1:0] a[NBEATS],
                           input logic [W-1:0] b[NBEATS]);
    logic [W-1:0] exp_sum;
    int lat;
    exp_sum = pair_sum(a, b);
    for (int i = 0; i < NBEATS; i++) send_beat(a[i], b[i]);
    wait_valid(lat);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL %s_latency: got %0d required %0d", name, lat, LAT);
    end
    checks++;
    if (W'(out_sum + out_carry) !== exp_sum) begin
      errors++;
      $display("FAIL %s_sum: got %h required %h", name, W'(out_sum + out_carry), exp_sum);
    end
`ifdef BOOTH_CSA_CPA_EN
    checks++;
    if (out_sum !== exp_sum || out_carry !== '0) begin
      errors++;
      $display("FAIL %s_cpa: got sum=%h carry=%h required %h/0", name, out_sum, out_carry, exp_sum);
    end
`endif
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_in_out: got %b required 0", name, in_ready);
    end
    handshake();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL %s_after_hs: got val/rdy/busy=%b required 010", name, {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_basic_sum();
    logic [W-1:0] a[NBEATS];
    logic [W-1:0] b[NBEATS];
    a = '{16'd1, 16'd3, 16'd5, 16'd7};
    b = '{16'd2, 16'd4, 16'd6, 16'd8};
    run_fixed("basic", a, b);
  endtask

  task automatic test_wrap();
    logic [W-1:0] a[NBEATS];
    logic [W-1:0] b[NBEATS];
    for (int i = 0; i < NBEATS; i++) begin
      a[i] = 16'hFFFF;
      b[i] = 16'hFFFF;
    end
    run_fixed("wrap", a, b);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a[NBEATS];
    logic [W-1:0] b[NBEATS];
    logic [W-1:0] exp_sum;
    int lat;
    for (int i = 0; i < NBEATS; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
    end
    exp_sum = pair_sum(a, b);
    for (int i = 0; i < NBEATS; i++) send_beat(a[i], b[i]);
    wait_valid(lat);
    // Five stalled cycles with junk beats offered; nothing may change.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pp0   = W'($urandom);
      in_pp1   = W'($urandom);
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || W'(out_sum + out_carry) !== exp_sum) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got val=%b rdy=%b sum=%h required 1/0/%h",
                 i, out_valid, in_ready, W'(out_sum + out_carry), exp_sum);
      end
    end
    in_valid = 1'b0;
    handshake();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got val/rdy=%b required 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] a[NBEATS];
    logic [W-1:0] b[NBEATS];
    int lat;
    int busy_bad;
    a = '{16'd1, 16'd3, 16'd5, 16'd7};
    b = '{16'd2, 16'd4, 16'd6, 16'd8};
    busy_bad = 0;
    for (int i = 0; i < NBEATS; i++) begin
      send_beat(a[i], b[i]);
      if (busy !== 1'b1) busy_bad++;
      if (i != NBEATS - 1) begin
        for (int g = 0; g < 2; g++) begin
          tick();
          if (busy !== 1'b1) busy_bad++;
        end
      end
    end
    wait_valid(lat);
    checks++;
    if (lat !== LAT || W'(out_sum + out_carry) !== 16'd36) begin
      errors++;
      $display("FAIL gaps_result: got lat=%0d sum=%h required %0d/0024",
               lat, W'(out_sum + out_carry), LAT);
    end
    checks++;
    if (busy !== 1'b1 || busy_bad != 0) begin
      errors++;
      $display("FAIL gaps_busy: got busy=%b low_cycles=%0d required 1/0", busy, busy_bad);
    end
    handshake();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL gaps_busy_end: got %b required 0", busy);
    end
  endtask

  task automatic test_clear();
    logic [W-1:0] a[NBEATS];
    logic [W-1:0] b[NBEATS];
    int lat;
    send_beat(16'h1234, 16'h1111);
    send_beat(16'h1234, 16'h1111);
    // Clear together with a third beat: the beat must be dropped.
    clear = 1'b1;
    send_beat(16'h1234, 16'h1111);
    clear = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL clear_acc: got rdy/val/busy=%b required 100", {in_ready, out_valid, busy});
    end
    for (int i = 0; i < NBEATS; i++) begin
      a[i] = 16'd1;
      b[i] = 16'd1;
      send_beat(a[i], b[i]);
    end
    wait_valid(lat);
    checks++;
    if (lat !== LAT || W'(out_sum + out_carry) !== pair_sum(a, b)) begin
      errors++;
      $display("FAIL clear_result: got lat=%0d sum=%h required %0d/%h",
               lat, W'(out_sum + out_carry), LAT, pair_sum(a, b));
    end
    // Clear while the result is offered and accepted in the same cycle.
    clear     = 1'b1;
    out_ready = 1'b1;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL clear_out: got rdy/val/busy=%b required 100", {in_ready, out_valid, busy});
    end
    // Clear on the cycle right after the last beat (ADD with CPA, OUT without).
    for (int i = 0; i < NBEATS; i++) send_beat(16'h00FF, 16'h0F0F);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    idle(2);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL clear_late: got rdy/val/busy=%b required 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a[NBEATS];
    logic [W-1:0] b[NBEATS];
    int lat;
    for (int i = 0; i < 3; i++) send_beat(W'($urandom), W'($urandom));
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_sum !== '0 || out_carry !== '0) begin
      errors++;
      $display("FAIL reset_async: got rdy/val/busy=%b sum=%h carry=%h required 100/0/0",
               {in_ready, out_valid, busy}, out_sum, out_carry);
    end
    tick();
    sys_rst_n = 1'b1;
    tick();
    for (int i = 0; i < NBEATS; i++) begin
      a[i] = 16'd2;
      b[i] = 16'd3;
      send_beat(a[i], b[i]);
    end
    wait_valid(lat);
    checks++;
    if (lat !== LAT || W'(out_sum + out_carry) !== 16'd20) begin
      errors++;
      $display("FAIL reset_result: got lat=%0d sum=%h required %0d/0014",
               lat, W'(out_sum + out_carry), LAT);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [W-1:0] a[NBEATS];
    logic [W-1:0] b[NBEATS];
    int lat;
    int stall;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NBEATS; i++) begin
        a[i] = W'($urandom);
        b[i] = W'($urandom);
        idle($urandom_range(0, 2));
        send_beat(a[i], b[i]);
      end
      wait_valid(lat);
      checks++;
      if (lat !== LAT || W'(out_sum + out_carry) !== pair_sum(a, b)) begin
        errors++;
        $display("FAIL random[%0d]: got lat=%0d sum=%h required %0d/%h",
                 r, lat, W'(out_sum + out_carry), LAT, pair_sum(a, b));
      end
      stall = $urandom_range(0, 3);
      idle(stall);
      checks++;
      if (out_valid !== 1'b1 || W'(out_sum + out_carry) !== pair_sum(a, b)) begin
        errors++;
        $display("FAIL random_hold[%0d]: got val=%b sum=%h required 1/%h",
                 r, out_valid, W'(out_sum + out_carry), pair_sum(a, b));
      end
      handshake();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    sys_rst_n = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_pp0    = '0;
    in_pp1    = '0;
    out_ready = 1'b0;

    test_reset();
    test_basic_sum();
    test_wrap();
    test_backpressure();
    test_gaps();
    test_clear();
    test_reset_mid();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
